// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/x/y in, busy/done/d/b out.
// The requester drives the master side; the subtractor implements the slave side.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b;

    modport master (
        output start, x, y,
        input  busy, done, d, b
    );

    modport slave (
        input  start, x, y,
        output busy, done, d, b
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = x - y, borrow b; LSB first, one bit per clock.
// Result lands WIDTH edges after the accepting edge; start is ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  io
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_sh_q, x_sh_d;
    logic [WIDTH-1:0] y_sh_q, y_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic xi, yi, diff, bout, last_bit;

    always_comb begin
        xi       = x_sh_q[0];
        yi       = y_sh_q[0];
        diff     = xi ^ yi ^ borrow_q;
        bout     = (~xi & yi) | (~(xi ^ yi) & borrow_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));

        state_d  = state_q;
        x_sh_d   = x_sh_q;
        y_sh_d   = y_sh_q;
        res_d    = res_q;
        d_d      = d_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        case (state_q)
            // DONE accepts a new start exactly like IDLE for back-to-back operation
            IDLE, DONE: begin
                state_d = IDLE;
                if (io.start) begin
                    x_sh_d   = io.x;
                    y_sh_d   = io.y;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                x_sh_d   = x_sh_q >> 1;
                y_sh_d   = y_sh_q >> 1;
                res_d    = {diff, res_q[WIDTH-1:1]};
                borrow_d = bout;
                cnt_d    = cnt_q + CW'(1);
                if (last_bit) begin
                    d_d     = {diff, res_q[WIDTH-1:1]};
                    b_d     = bout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_sh_q   <= '0;
            y_sh_q   <= '0;
            res_q    <= '0;
            d_q      <= '0;
            b_q      <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_sh_q   <= x_sh_d;
            y_sh_q   <= y_sh_d;
            res_q    <= res_d;
            d_q      <= d_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign io.busy = (state_q == SHIFT);
    assign io.done = (state_q == DONE);
    assign io.d    = d_q;
    assign io.b    = b_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst8, rst4;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .io(if8.slave));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .io(if4.slave));

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ticks until done; also notes whether d moved while the op was in flight.
    task automatic wait_done8(input logic [7:0] prev, output int edges, output logic stable);
        edges  = 0;
        stable = 1'b1;
        while (1) begin
            tick();
            edges++;
            if (if8.done) break;
            if (if8.d !== prev) stable = 1'b0;
            if (edges >= 40) break;
        end
    endtask

    task automatic wait_done4(output int edges);
        edges = 0;
        while (1) begin
            tick();
            edges++;
            if (if4.done || edges >= 40) break;
        end
    endtask

    task automatic op8(input logic [7:0] xv, input logic [7:0] yv,
                       input logic [7:0] ed, input logic eb, input string name);
        logic [7:0] prev;
        int         edges;
        logic       stable;
        prev      = if8.d;
        if8.x     = xv;
        if8.y     = yv;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        chk({name, " busy"}, 32'(if8.busy), 32'd1);
        wait_done8(prev, edges, stable);
        chk({name, " latency"}, 32'(edges), 32'd8);
        chk({name, " d"}, 32'(if8.d), 32'(ed));
        chk({name, " b"}, 32'(if8.b), 32'(eb));
        chk({name, " d stable"}, 32'(stable), 32'd1);
        tick();
        chk({name, " done 1-cycle"}, 32'(if8.done), 32'd0);
    endtask

    initial begin
        int         edges;
        logic       stable;
        logic       seen;
        logic [3:0] rx, ry;

        vecs[0] = '{x: 8'h5A, y: 8'h3C, ed: 8'h1E, eb: 1'b0};
        vecs[1] = '{x: 8'h00, y: 8'h01, ed: 8'hFF, eb: 1'b1};
        vecs[2] = '{x: 8'h80, y: 8'h80, ed: 8'h00, eb: 1'b0};
        vecs[3] = '{x: 8'h00, y: 8'hFF, ed: 8'h01, eb: 1'b1};
        vecs[4] = '{x: 8'hFF, y: 8'h00, ed: 8'hFF, eb: 1'b0};
        vecs[5] = '{x: 8'h3C, y: 8'h5A, ed: 8'hE2, eb: 1'b1};

        rst8 = 1'b1; rst4 = 1'b1;
        if8.start = 1'b0; if8.x = '0; if8.y = '0;
        if4.start = 1'b0; if4.x = '0; if4.y = '0;
        tick();
        tick();
        chk("reset busy", 32'(if8.busy), 32'd0);
        chk("reset done", 32'(if8.done), 32'd0);
        chk("reset d", 32'(if8.d), 32'd0);
        chk("reset b", 32'(if8.b), 32'd0);
        rst8 = 1'b0; rst4 = 1'b0;
        tick();

        foreach (vecs[i])
            op8(vecs[i].x, vecs[i].y, vecs[i].ed, vecs[i].eb, $sformatf("vec%0d", i));

        // start held three cycles, operands changed after acceptance
        if8.x = 8'h5A; if8.y = 8'h3C; if8.start = 1'b1;
        tick();
        if8.x = 8'hFF; if8.y = 8'h00;
        tick();
        tick();
        if8.start = 1'b0;
        chk("held busy", 32'(if8.busy), 32'd1);
        wait_done8(8'hE2, edges, stable);
        chk("held latency", 32'(edges + 2), 32'd8);
        chk("held d", 32'(if8.d), 32'h1E);
        chk("held b", 32'(if8.b), 32'd0);
        chk("held d stable", 32'(stable), 32'd1);

        // back-to-back start issued in the DONE cycle
        if8.x = 8'h10; if8.y = 8'h20; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        chk("b2b busy", 32'(if8.busy), 32'd1);
        chk("b2b old d", 32'(if8.d), 32'h1E);
        wait_done8(8'h1E, edges, stable);
        chk("b2b latency", 32'(edges), 32'd8);
        chk("b2b d", 32'(if8.d), 32'hF0);
        chk("b2b b", 32'(if8.b), 32'd1);
        chk("b2b d stable", 32'(stable), 32'd1);
        tick();

        // reset sampled at the end of the 4th SHIFT cycle
        if8.x = 8'h5A; if8.y = 8'h3C; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        chk("abort busy", 32'(if8.busy), 32'd0);
        chk("abort done", 32'(if8.done), 32'd0);
        chk("abort d", 32'(if8.d), 32'd0);
        chk("abort b", 32'(if8.b), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if8.done || if8.busy) seen = 1'b1;
        end
        chk("abort no done", 32'(seen), 32'd0);

        // WIDTH=4 directed case
        if4.x = 4'h3; if4.y = 4'h7; if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        wait_done4(edges);
        chk("w4 latency", 32'(edges), 32'd4);
        chk("w4 d", 32'(if4.d), 32'hC);
        chk("w4 b", 32'(if4.b), 32'd1);
        tick();

        for (int i = 0; i < 1000; i++) begin
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            if4.x = rx; if4.y = ry; if4.start = 1'b1;
            tick();
            if4.start = 1'b0;
            wait_done4(edges);
            chk($sformatf("rnd%0d %0h-%0h", i, rx, ry),
                {27'd0, (rx < ry) ? 1'b1 : 1'b0, 4'(rx - ry)},
                {27'd0, if4.b, if4.d});
            if (edges != 4) chk($sformatf("rnd%0d latency", i), 32'(edges), 32'd4);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
